// File: rtl/mem_arbiter_if.sv
// Signal bundle between the core's instruction/data ports, the arbiter and the shared memory port.
// The arbiter connects through the slave modport; the environment driving it uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_start;
  logic              i_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;

  logic              d_cmd_start;
  logic              d_cmd_write;
  logic              d_cmd_ready;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_wmask;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rdata_valid;

  logic              mem_start;
  logic              mem_write;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;

  modport slave (
    input  i_start, i_addr,
    output i_ready, i_data, i_valid,
    input  d_cmd_start, d_cmd_write, d_addr, d_wdata, d_wmask,
    output d_cmd_ready, d_rdata, d_rdata_valid,
    output mem_start, mem_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rdata, mem_rdata_valid
  );

  modport master (
    output i_start, i_addr,
    input  i_ready, i_data, i_valid,
    output d_cmd_start, d_cmd_write, d_addr, d_wdata, d_wmask,
    input  d_cmd_ready, d_rdata, d_rdata_valid,
    input  mem_start, mem_write, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rdata, mem_rdata_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory command port between the instruction and data ports.
// Each port owns a one-entry request buffer; one memory command is outstanding at a time.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  state_t            state, state_nxt;
  logic              i_buf_vld;
  logic [ADDR_W-1:0] i_buf_addr;
  logic              d_buf_vld, d_buf_write;
  logic [ADDR_W-1:0] d_buf_addr;
  logic [DATA_W-1:0] d_buf_wdata, d_buf_wmask;
  logic              owner, last_grant;
  logic              grant_vld, grant_sel, cmd_done, rsp_done, release_buf;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r, mem_wmask_r;
  logic              i_valid_r, d_valid_r;
  logic [DATA_W-1:0] i_data_r, d_rdata_r;

  assign bus.i_ready       = !i_buf_vld;
  assign bus.d_cmd_ready   = !d_buf_vld;
  assign bus.mem_start     = (state == S_REQ);
  assign bus.mem_write     = mem_write_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.mem_wmask     = mem_wmask_r;
  assign bus.i_valid       = i_valid_r;
  assign bus.i_data        = i_data_r;
  assign bus.d_rdata_valid = d_valid_r;
  assign bus.d_rdata       = d_rdata_r;
  assign release_buf       = cmd_done || rsp_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_sel = GNT_INST;
    cmd_done  = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_buf_vld || d_buf_vld) begin
          grant_vld = 1'b1;
          // On a tie the port that lost last time wins
          grant_sel = (d_buf_vld && (!i_buf_vld || last_grant == GNT_INST)) ? GNT_DATA : GNT_INST;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_ready) begin
          if (mem_write_r) begin
            cmd_done  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_rdata_valid) begin
          rsp_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_buf_vld <= 1'b0;
      d_buf_vld <= 1'b0;
    end else begin
      if (bus.i_start && !i_buf_vld)                     i_buf_vld <= 1'b1;
      else if (release_buf && owner == GNT_INST)         i_buf_vld <= 1'b0;
      if (bus.d_cmd_start && !d_buf_vld)                 d_buf_vld <= 1'b1;
      else if (release_buf && owner == GNT_DATA)         d_buf_vld <= 1'b0;
    end
  end

  // Buffer payload is only meaningful while its valid bit is set
  always_ff @(posedge clk) begin
    if (bus.i_start && !i_buf_vld) i_buf_addr <= bus.i_addr;
    if (bus.d_cmd_start && !d_buf_vld) begin
      d_buf_addr  <= bus.d_addr;
      d_buf_write <= bus.d_cmd_write;
      d_buf_wdata <= bus.d_wdata;
      d_buf_wmask <= bus.d_wmask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= GNT_INST;
      last_grant  <= GNT_INST;
      mem_write_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wmask_r <= '0;
    end else if (grant_vld) begin
      owner      <= grant_sel;
      last_grant <= grant_sel;
      if (grant_sel == GNT_DATA) begin
        mem_write_r <= d_buf_write;
        mem_addr_r  <= d_buf_addr;
        mem_wdata_r <= d_buf_wdata;
        mem_wmask_r <= d_buf_wmask;
      end else begin
        mem_write_r <= 1'b0;
        mem_addr_r  <= i_buf_addr;
        mem_wdata_r <= '0;
        mem_wmask_r <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_valid_r <= 1'b0;
      d_valid_r <= 1'b0;
      i_data_r  <= '0;
      d_rdata_r <= '0;
    end else begin
      i_valid_r <= rsp_done && (owner == GNT_INST);
      d_valid_r <= rsp_done && (owner == GNT_DATA);
      if (rsp_done && owner == GNT_INST) i_data_r  <= bus.mem_rdata;
      if (rsp_done && owner == GNT_DATA) d_rdata_r <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected memory commands and
// read responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  cmd_t        cmd_q[$];
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mem_start(input string name);
    int n = 0;
    while (!bus.mem_start && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_mem_start_timeout"}, {31'd0, bus.mem_start}, 32'd1);
  endtask

  // Accept the pending read (mem_ready must be 1), reply two cycles later
  task automatic mem_reply(input logic [31:0] data);
    tick();
    tick();
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = data;
    tick();
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = 32'h0;
  endtask

  task automatic d_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] wmask);
    int n = 0;
    bus.d_cmd_start = 1'b1;
    bus.d_cmd_write = wr;
    bus.d_addr      = addr;
    bus.d_wdata     = wdata;
    bus.d_wmask     = wmask;
    while (!bus.d_cmd_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    bus.d_cmd_start = 1'b0;
  endtask

  task automatic i_req(input logic [31:0] addr);
    int n = 0;
    bus.i_start = 1'b1;
    bus.i_addr  = addr;
    while (!bus.i_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_i_ready"},       {31'd0, bus.i_ready},       32'd1);
    chk({tag, "_d_cmd_ready"},   {31'd0, bus.d_cmd_ready},   32'd1);
    chk({tag, "_i_valid"},       {31'd0, bus.i_valid},       32'd0);
    chk({tag, "_d_rdata_valid"}, {31'd0, bus.d_rdata_valid}, 32'd0);
    chk({tag, "_mem_start"},     {31'd0, bus.mem_start},     32'd0);
    chk({tag, "_mem_write"},     {31'd0, bus.mem_write},     32'd0);
    chk({tag, "_mem_addr"},      bus.mem_addr,               32'd0);
    chk({tag, "_mem_wdata"},     bus.mem_wdata,              32'd0);
    chk({tag, "_mem_wmask"},     bus.mem_wmask,              32'd0);
    chk({tag, "_i_data"},        bus.i_data,                 32'd0);
    chk({tag, "_d_rdata"},       bus.d_rdata,                32'd0);
  endtask

  // Monitor: accepted commands and response pulses are popped against the scoreboard
  initial begin
    cmd_t        c;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (bus.mem_start && bus.mem_ready) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got addr 0x%08h, no command expected", bus.mem_addr);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_write", {31'd0, bus.mem_write}, {31'd0, c.wr});
          chk("cmd_addr",  bus.mem_addr,  c.addr);
          chk("cmd_wdata", bus.mem_wdata, c.wdata);
          chk("cmd_wmask", bus.mem_wmask, c.wmask);
        end
      end
      if (bus.i_valid) begin
        if (i_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_i_valid: got data 0x%08h, no pulse expected", bus.i_data);
        end else begin
          e = i_q.pop_front();
          chk("i_data", bus.i_data, e);
        end
      end
      if (bus.d_rdata_valid) begin
        if (d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_d_rdata_valid: got data 0x%08h, no pulse expected", bus.d_rdata);
        end else begin
          e = d_q.pop_front();
          chk("d_rdata", bus.d_rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.i_start = 0; bus.i_addr = 0;
    bus.d_cmd_start = 0; bus.d_cmd_write = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wmask = 0;
    bus.mem_ready = 1; bus.mem_rdata = 0; bus.mem_rdata_valid = 0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single write with best-case latency
    cmd_q.push_back('{1'b1, 32'h100, 32'hDEADBEEF, 32'hFFFFFFFF});
    bus.d_cmd_start = 1; bus.d_cmd_write = 1; bus.d_addr = 32'h100;
    bus.d_wdata = 32'hDEADBEEF; bus.d_wmask = 32'hFFFFFFFF;
    tick();
    bus.d_cmd_start = 0;
    chk("wr_ready_busy", {31'd0, bus.d_cmd_ready}, 32'd0);
    chk("wr_start_e0",   {31'd0, bus.mem_start},   32'd0);
    tick();
    chk("wr_start_e1",   {31'd0, bus.mem_start},   32'd1);
    tick();
    chk("wr_start_e2",   {31'd0, bus.mem_start},   32'd0);
    chk("wr_ready_free", {31'd0, bus.d_cmd_ready}, 32'd1);
    tick();

    // Instruction read
    cmd_q.push_back('{1'b0, 32'h80, 32'h0, 32'h0});
    i_q.push_back(32'h00000013);
    i_req(32'h80);
    wait_mem_start("iread");
    mem_reply(32'h00000013);
    tick(); tick();
    chk("iread_hold_data",  bus.i_data,               32'h00000013);
    chk("iread_valid_low",  {31'd0, bus.i_valid},     32'd0);
    chk("iread_ready_free", {31'd0, bus.i_ready},     32'd1);

    // Tie 1: data (write) first, then instruction
    cmd_q.push_back('{1'b1, 32'h200, 32'hCAFEF00D, 32'hFF00FF00});
    cmd_q.push_back('{1'b0, 32'h84, 32'h0, 32'h0});
    i_q.push_back(32'h11111111);
    bus.d_cmd_start = 1; bus.d_cmd_write = 1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hCAFEF00D; bus.d_wmask = 32'hFF00FF00;
    bus.i_start = 1; bus.i_addr = 32'h84;
    tick();
    bus.d_cmd_start = 0; bus.i_start = 0;
    wait_mem_start("tie1_d");
    tick();
    wait_mem_start("tie1_i");
    mem_reply(32'h11111111);
    tick();

    // Tie 2: data wins again since instruction was granted last
    cmd_q.push_back('{1'b0, 32'h300, 32'hA5A5A5A5, 32'h0F0F0F0F});
    cmd_q.push_back('{1'b0, 32'h88, 32'h0, 32'h0});
    d_q.push_back(32'h22222222);
    i_q.push_back(32'h33333333);
    bus.d_cmd_start = 1; bus.d_cmd_write = 0; bus.d_addr = 32'h300;
    bus.d_wdata = 32'hA5A5A5A5; bus.d_wmask = 32'h0F0F0F0F;
    bus.i_start = 1; bus.i_addr = 32'h88;
    tick();
    bus.d_cmd_start = 0; bus.i_start = 0;
    wait_mem_start("tie2_d");
    mem_reply(32'h22222222);
    wait_mem_start("tie2_i");
    mem_reply(32'h33333333);
    tick();

    // Backpressure: command held stable while mem_ready is low
    bus.mem_ready = 0;
    cmd_q.push_back('{1'b1, 32'h400, 32'h12345678, 32'h0000FFFF});
    d_req(1'b1, 32'h400, 32'h12345678, 32'h0000FFFF);
    wait_mem_start("bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp_start", {31'd0, bus.mem_start}, 32'd1);
      chk("bp_write", {31'd0, bus.mem_write}, 32'd1);
      chk("bp_addr",  bus.mem_addr,  32'h400);
      chk("bp_wdata", bus.mem_wdata, 32'h12345678);
      chk("bp_wmask", bus.mem_wmask, 32'h0000FFFF);
      tick();
    end
    bus.mem_ready = 1;
    tick();
    chk("bp_start_done", {31'd0, bus.mem_start},   32'd0);
    chk("bp_ready_free", {31'd0, bus.d_cmd_ready}, 32'd1);
    tick();

    // Stray mem_rdata_valid in IDLE and in REQ
    bus.mem_rdata_valid = 1; bus.mem_rdata = 32'hBAD0BAD0;
    tick();
    bus.mem_rdata_valid = 0; bus.mem_rdata = 0;
    chk("stray_idle_start", {31'd0, bus.mem_start}, 32'd0);
    chk("stray_idle_iready", {31'd0, bus.i_ready},  32'd1);
    bus.mem_ready = 0;
    cmd_q.push_back('{1'b0, 32'h90, 32'h0, 32'h0});
    i_q.push_back(32'h44444444);
    i_req(32'h90);
    wait_mem_start("stray_req");
    bus.mem_rdata_valid = 1; bus.mem_rdata = 32'hBAD1BAD1;
    tick();
    bus.mem_rdata_valid = 0; bus.mem_rdata = 0;
    chk("stray_req_start", {31'd0, bus.mem_start}, 32'd1);
    bus.mem_ready = 1;
    mem_reply(32'h44444444);
    tick();

    // Reset while waiting for read data; the late response must be dropped
    cmd_q.push_back('{1'b0, 32'h500, 32'h0, 32'h0});
    d_req(1'b0, 32'h500, 32'h0, 32'h0);
    wait_mem_start("rst_wait");
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    tick();
    rst = 1'b0;
    bus.mem_rdata_valid = 1; bus.mem_rdata = 32'h55555555;
    tick();
    bus.mem_rdata_valid = 0; bus.mem_rdata = 0;
    tick();
    tick();
    chk("post_rst_d_ready", {31'd0, bus.d_cmd_ready}, 32'd1);
    chk("post_rst_start",   {31'd0, bus.mem_start},   32'd0);
    chk("post_rst_d_rdata", bus.d_rdata,              32'd0);

    tick();
    chk("cmd_q_drained", cmd_q.size(), 32'd0);
    chk("i_q_drained",   i_q.size(),   32'd0);
    chk("d_q_drained",   d_q.size(),   32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
